// File: rtl/demux_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | demux_pkg                                                                  |
// | Shared FSM encoding and select-width helper for the stream demultiplexer.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package demux_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } demux_state_e;

    // A two-output demux still needs one select bit, so the width never drops below 1.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_out_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | demux_out_reg                                                              |
// | One-entry valid/ready output register; data and last persist after pop.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module demux_out_reg #(
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_load,
    input  logic [DW-1:0] i_data,
    input  logic          i_last,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic          o_last
);

    logic          r_valid;
    logic [DW-1:0] r_data;
    logic          r_last;

    // A load wins over a pop, so a full-rate stream keeps valid asserted.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule
`default_nettype wire

// File: rtl/demux_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | demux_stream                                                               |
// | Packet-aware 1-to-N valid/ready demultiplexer with per-output registers.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module demux_stream
    import demux_pkg::*;
#(
    parameter  int DW = 8,
    parameter  int N  = 4,
    localparam int SW = sel_width(N)
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_valid,
    input  logic [DW-1:0]   i_data,
    input  logic            i_last,
    input  logic [SW-1:0]   i_sel,
    output logic            o_ready,
    output logic [N-1:0]    o_valid,
    output logic [N*DW-1:0] o_data,
    output logic [N-1:0]    o_last,
    input  logic [N-1:0]    i_ready,
    output logic            o_lock,
    output logic            o_drop
);

    localparam logic [SW:0] C_N = (SW+1)'(N);

    demux_state_e  r_state;
    demux_state_e  w_state_nxt;
    logic [SW-1:0] r_sel;
    logic [SW-1:0] w_sel_nxt;
    logic [SW-1:0] w_tgt;
    logic          w_tgt_ok;
    logic          w_xfer;
    logic          r_drop;
    logic [N-1:0]  w_load;

    assign w_tgt    = (r_state == ST_IDLE) ? i_sel : r_sel;
    assign w_tgt_ok = ({1'b0, w_tgt} < C_N);
    assign w_xfer   = i_valid & o_ready;

    // Out-of-range targets are always ready so a dropped packet drains at full rate.
    always_comb begin
        o_ready = 1'b1;
        w_load  = '0;
        for (int k = 0; k < N; k++) begin
            if (w_tgt_ok && (w_tgt == SW'(k))) begin
                o_ready   = ~o_valid[k] | i_ready[k];
                w_load[k] = w_xfer;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer && !i_last) begin
                    w_state_nxt = ST_LOCK;
                    w_sel_nxt   = i_sel;
                end
            end
            ST_LOCK: begin
                if (w_xfer && i_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_drop  <= w_xfer & ~w_tgt_ok;
        end
    end

    generate
        for (genvar k = 0; k < N; k++) begin : g_out
            demux_out_reg #(
                .DW (DW)
            ) u_out_reg (
                .i_clk   (i_clk),
                .i_rstn  (i_rstn),
                .i_load  (w_load[k]),
                .i_data  (i_data),
                .i_last  (i_last),
                .i_ready (i_ready[k]),
                .o_valid (o_valid[k]),
                .o_data  (o_data[k*DW +: DW]),
                .o_last  (o_last[k])
            );
        end
    endgenerate

    assign o_lock = (r_state == ST_LOCK);
    assign o_drop = r_drop;

endmodule
`default_nettype wire

// File: doc/demux_stream.md
# demux_stream

Packet-aware 1-to-N stream demultiplexer: the routing counterpart of the team's 2:1 muxes on the combinational-logic track. It accepts one valid/ready input stream and steers each beat to one of N output streams. The select is sampled on the first beat of a packet and held until the beat carrying `last`. Each output has a one-entry register stage, so the block sits between a single producer and N independent consumers.

## Interface
- `DW`, 8, data width in bits.
- `N`, 4, number of output streams (2..16; need not be a power of two).
- `SW`, `$clog2(N)` (minimum 1), select width; derived, not overridden.

- `i_clk`  in  1  clock; all logic rising-edge.
- `i_rstn`  in  1  reset; asynchronous assert, active-low.
- `i_valid`  in  1  input beat valid.
- `i_data`  in  DW  input beat data.
- `i_last`  in  1  final beat of the packet.
- `i_sel`  in  SW  destination index; sampled only on a packet's first beat.
- `o_ready`  out  1  input may be accepted this cycle.
- `o_valid`  out  N  per-output beat valid.
- `o_data`  out  N*DW  output k occupies bits `[k*DW +: DW]`.
- `o_last`  out  N  per-output last flag.
- `i_ready`  in  N  per-output consumer ready.
- `o_lock`  out  1  a packet is in progress and the select is latched.
- `o_drop`  out  1  one-cycle pulse when an accepted beat is discarded because its select is ≥ N.

## Operation
**Handshakes**
- Input transfer occurs when `i_valid & o_ready`.
- Output k transfer occurs when `o_valid[k] & i_ready[k]`.

**Target selection**
- `tgt = (state==IDLE) ? i_sel : sel_q`.

**Ready**
- `o_ready = ~o_valid[tgt] | i_ready[tgt]`. Ready is combinational through `i_ready`; there is no bubble on a full-rate stream.
- If `tgt ≥ N`, `o_ready = 1`.

**FSM (2 states)**
- IDLE, transfer with `i_last=0`:
  - `sel_q <= i_sel`, go to LOCK.
  - If `i_sel ≥ N`, latch it anyway; the whole packet is dropped.
- IDLE, transfer with `i_last=1`: single-beat packet, stay in IDLE.
- LOCK: `i_sel` is ignored. A transfer with `i_last=1` returns to IDLE.
- `o_lock = (state==LOCK)`.

**Output register k**
- Load `{i_data, i_last}` and set `o_valid[k]` on a transfer with `tgt==k` (k < N).
- Clear `o_valid[k]` on an output transfer with no simultaneous load.
- Simultaneous output transfer and load: new data is loaded and `o_valid[k]` stays 1.
- While `o_valid[k] & ~i_ready[k]`, `o_data[k]` and `o_last[k]` are held stable.
- `o_data` and `o_last` retain their value after the output pops; they are not zeroed.

**Drop**
- A transfer with `tgt ≥ N` loads no output and pulses `o_drop` (registered) the next cycle.

**Independence and ordering**
- Outputs are fully independent: a stalled output blocks only input beats targeting it.
- There is no reordering, and no interleaving of packets; the input is strictly in order.

## Timing
**Reset values** (asynchronous on `i_rstn` low)
- Outputs: `o_valid=0`, `o_data=0`, `o_last=0`, `o_drop=0`, `o_lock=0`.
- Internal: state=IDLE, `sel_q=0`.
- `o_ready` reads 1 while in reset state.

**Latency and throughput**
- Input transfer at edge t gives `o_valid[k]=1` from t+1.
- Throughput is 1 beat/cycle whenever the target consumer holds `i_ready` high.

**Reset mid-packet**
- Packet state is abandoned, FSM returns to IDLE, and all register contents are invalidated.
- The first post-reset beat is treated as a packet start.

**Other rules**
- `i_ready[k]` is ignored while `o_valid[k]=0`.
- `i_data`, `i_last` and `i_sel` are don't-care while `i_valid=0`.

## Structure
- Shared package `demux_pkg` holds the FSM state encoding `ST_IDLE`/`ST_LOCK` and a `clog2`-based `SW` helper.
- Sub-module `demux_out_reg`:
  - One-entry register with valid/ready, ports load/data/last/ready.
  - Instantiated N times by generate.
- Top contains the FSM, `sel_q`, target decode, ready mux and drop logic.

## Test plan
- Single-beat packets with `i_sel` = 0,1,2,3 and data 0x11,0x22,0x33,0x44, all `i_ready=1` → each value appears on its own output one cycle later with `o_last=1`; `o_lock` never rises.
- 4-beat packet (`i_sel=2`, data 0xA0..0xA3) while `i_sel` toggles randomly after beat 0 → all four beats appear on output 2 in order; `o_lock` is high from beat 0 until beat 3 is accepted.
- Output 1 holds `i_ready[1]=0` for 5 cycles while a packet to output 1 is followed by a packet to output 3:
  - `o_ready` drops after the first beat to output 1.
  - `o_data[1]` stays stable.
  - After release, both packets complete.
- Back-to-back stream to output 0 with `i_ready[0]=1` → one beat per cycle; `o_valid[0]` stays high with no gap.
- `N=3`, packet with `i_sel=3` of 3 beats → `o_ready=1` throughout, no `o_valid` asserts, `o_drop` pulses three times, and FSM returns to IDLE.
- Assert `i_rstn=0` after beat 1 of a 4-beat packet to output 1 → all `o_valid` are 0 immediately; the next beat with `i_sel=0` routes to output 0.
